// File: rtl/mdu_hilo_if.sv
// EX-stage request / HI-LO write-port bundle between the pipeline and the multiply/divide unit.
interface mdu_hilo_if #(parameter int DATA_W = 32);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              cancel;
  logic              busy;
  logic              we_hi;
  logic [DATA_W-1:0] hi_data_out;
  logic              we_lo;
  logic [DATA_W-1:0] lo_data_out;

  modport master (
    output start, op, opa, opb, cancel,
    input  busy, we_hi, hi_data_out, we_lo, lo_data_out
  );

  modport slave (
    input  start, op, opa, opb, cancel,
    output busy, we_hi, hi_data_out, we_lo, lo_data_out
  );
endinterface

// File: rtl/mdu_hilo_writer.sv
// MIPS multiply/divide unit driving the HI/LO write port; MTHI/MTLO write 1 cycle after accept,
// MULT 2 cycles, DIV DATA_W+2 cycles (2 on divide-by-zero); busy stalls the pipeline meanwhile.
module mdu_hilo_writer #(
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  mdu_hilo_if.slave bus
);

  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   a_q;    // multiplicand, or dividend magnitude shifting into quotient
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   rem_q;
  logic                sgn_q;
  logic                neg_quo;
  logic                neg_rem;
  logic                dz_q;

  logic                op_valid;
  logic                div_signed;
  logic                opb_zero;
  logic [DATA_W-1:0]   opa_mag;
  logic [DATA_W-1:0]   opb_mag;
  logic [2*DATA_W-1:0] mul_a;
  logic [2*DATA_W-1:0] mul_b;
  logic [2*DATA_W-1:0] product;
  logic [DATA_W:0]     rem_sh;
  logic                rem_ge;

  always_comb begin
    op_valid   = bus.start && (bus.op != 3'd0) && (bus.op != 3'd7);
    div_signed = (bus.op == OP_DIV);
    opb_zero   = (bus.opb == '0);
    // Divide-by-zero keeps the raw dividend so it can be returned unchanged on HI
    opa_mag    = (div_signed && bus.opa[DATA_W-1] && !opb_zero) ? -bus.opa : bus.opa;
    opb_mag    = (div_signed && bus.opb[DATA_W-1]) ? -bus.opb : bus.opb;
    mul_a      = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
    mul_b      = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
    product    = mul_a * mul_b;
    rem_sh     = {rem_q, a_q[DATA_W-1]};
    rem_ge     = (rem_sh >= {1'b0, b_q});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      a_q             <= '0;
      b_q             <= '0;
      rem_q           <= '0;
      sgn_q           <= 1'b0;
      neg_quo         <= 1'b0;
      neg_rem         <= 1'b0;
      dz_q            <= 1'b0;
      bus.busy        <= 1'b0;
      bus.we_hi       <= 1'b0;
      bus.we_lo       <= 1'b0;
      bus.hi_data_out <= '0;
      bus.lo_data_out <= '0;
    end else begin
      bus.we_hi <= 1'b0;
      bus.we_lo <= 1'b0;
      if (bus.cancel) begin
        state    <= IDLE;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (op_valid) begin
              cnt   <= '0;
              rem_q <= '0;
              case (bus.op)
                OP_MTHI: begin
                  bus.we_hi       <= 1'b1;
                  bus.hi_data_out <= bus.opa;
                  state           <= DONE;
                end
                OP_MTLO: begin
                  bus.we_lo       <= 1'b1;
                  bus.lo_data_out <= bus.opa;
                  state           <= DONE;
                end
                OP_MULT, OP_MULTU: begin
                  a_q      <= bus.opa;
                  b_q      <= bus.opb;
                  sgn_q    <= (bus.op == OP_MULT);
                  bus.busy <= 1'b1;
                  state    <= MUL;
                end
                default: begin
                  a_q      <= opa_mag;
                  b_q      <= opb_mag;
                  neg_quo  <= div_signed && (bus.opa[DATA_W-1] ^ bus.opb[DATA_W-1]);
                  neg_rem  <= div_signed && bus.opa[DATA_W-1];
                  dz_q     <= opb_zero;
                  bus.busy <= 1'b1;
                  state    <= DIV;
                end
              endcase
            end
          end
          MUL: begin
            bus.hi_data_out <= product[2*DATA_W-1:DATA_W];
            bus.lo_data_out <= product[DATA_W-1:0];
            bus.we_hi       <= 1'b1;
            bus.we_lo       <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= DONE;
          end
          DIV: begin
            if (dz_q) begin
              bus.hi_data_out <= a_q;
              bus.lo_data_out <= '1;
              bus.we_hi       <= 1'b1;
              bus.we_lo       <= 1'b1;
              bus.busy        <= 1'b0;
              state           <= DONE;
            end else if (cnt == CW'(DATA_W)) begin
              bus.lo_data_out <= neg_quo ? -a_q : a_q;
              bus.hi_data_out <= neg_rem ? -rem_q : rem_q;
              bus.we_hi       <= 1'b1;
              bus.we_lo       <= 1'b1;
              bus.busy        <= 1'b0;
              state           <= DONE;
            end else begin
              // Restoring step: trial-subtract, keep the difference only when it fits
              rem_q <= rem_ge ? DATA_W'(rem_sh - {1'b0, b_q}) : rem_sh[DATA_W-1:0];
              a_q   <= {a_q[DATA_W-2:0], rem_ge};
              cnt   <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo_writer.sv
// Bench for mdu_hilo_writer: directed MIPS MDU cases then randomized traffic, every cycle
// checked against an event-schedule reference model built on plain integer arithmetic.
module tb_mdu_hilo_writer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mdu_hilo_if #(.DATA_W(W)) bus();
  mdu_hilo_writer #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // {hi, lo} as the architecture defines each operation
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (op)
      3'd1: res = sa * sb;
      3'd2: res = {32'b0, a} * {32'b0, b};
      3'd3: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd4: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Posedges from accept to the write edge
  function automatic int write_delay(input logic [2:0] op, input logic [31:0] b);
    if (op == 3'd1 || op == 3'd2) return 1;
    if (op == 3'd3 || op == 3'd4) return (b == 0) ? 1 : W + 1;
    return 0;
  endfunction

  // Reference model: tracks which posedge may accept and when the pending write lands
  int          k = 0;
  int          accept_at = 0;
  int          fire_at = 0;
  bit          job = 1'b0;
  logic [63:0] job_res;
  logic        m_busy, m_we_hi, m_we_lo;
  logic [31:0] m_hi, m_lo;

  always @(posedge clk) begin
    k = k + 1;
    m_we_hi = 1'b0;
    m_we_lo = 1'b0;
    if (!rst) begin
      m_busy = 1'b0; m_hi = '0; m_lo = '0;
      job = 1'b0; accept_at = k + 1;
    end else if (bus.cancel) begin
      m_busy = 1'b0; job = 1'b0; accept_at = k + 1;
    end else if (job) begin
      if (k == fire_at) begin
        m_we_hi = 1'b1; m_we_lo = 1'b1;
        {m_hi, m_lo} = job_res;
        m_busy = 1'b0; job = 1'b0; accept_at = k + 2;
      end
    end else if (k >= accept_at && bus.start && (bus.op inside {[3'd1:3'd6]})) begin
      if (bus.op == 3'd5) begin
        m_we_hi = 1'b1; m_hi = bus.opa; accept_at = k + 2;
      end else if (bus.op == 3'd6) begin
        m_we_lo = 1'b1; m_lo = bus.opa; accept_at = k + 2;
      end else begin
        job = 1'b1;
        job_res = ref_result(bus.op, bus.opa, bus.opb);
        fire_at = k + write_delay(bus.op, bus.opb);
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (k >= 1) begin
      vectors++;
      if (bus.busy !== m_busy || bus.we_hi !== m_we_hi || bus.we_lo !== m_we_lo ||
          bus.hi_data_out !== m_hi || bus.lo_data_out !== m_lo) begin
        miscompares++;
        $display("FAIL cycle%0d outputs: got busy=%b we_hi=%b we_lo=%b hi=%h lo=%h, want busy=%b we_hi=%b we_lo=%b hi=%h lo=%h",
                 k, bus.busy, bus.we_hi, bus.we_lo, bus.hi_data_out, bus.lo_data_out,
                 m_busy, m_we_hi, m_we_lo, m_hi, m_lo);
      end
    end
  end

  task automatic pin(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.opa = a; bus.opb = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 3'd0;
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'd0; bus.opa = '0; bus.opb = '0; bus.cancel = 1'b0;
    rst = 1'b0;

    pin("model_mult",   ref_result(3'd1, 32'hFFFF_FFFE, 32'd3), 64'hFFFF_FFFF_FFFF_FFFA);
    pin("model_multu",  ref_result(3'd2, 32'hFFFF_FFFE, 32'd3), 64'h0000_0002_FFFF_FFFA);
    pin("model_div",    ref_result(3'd3, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    pin("model_divu",   ref_result(3'd4, 32'd100, 32'd7),      64'h0000_0002_0000_000E);
    pin("model_div_ovf",ref_result(3'd3, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    pin("model_div0",   ref_result(3'd4, 32'd5, 32'd0),        64'h0000_0005_FFFF_FFFF);

    idle(3);
    rst = 1'b1;
    req(3'd1, 32'hFFFF_FFFE, 32'd3);          idle(3);
    req(3'd2, 32'hFFFF_FFFE, 32'd3);          idle(3);
    req(3'd3, 32'hFFFF_FFF9, 32'd2);          idle(36);
    req(3'd4, 32'd100, 32'd7);                idle(36);
    req(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);  idle(36);
    req(3'd4, 32'd5, 32'd0);                  idle(3);
    req(3'd3, 32'h1234_5678, 32'd0);          idle(3);
    req(3'd5, 32'h1234_5678, 32'd0);          idle(2);
    req(3'd6, 32'h9ABC_DEF0, 32'd0);          idle(2);

    // start during a divide's busy window is ignored
    req(3'd4, 32'd1000, 32'd3);  idle(4);
    req(3'd1, 32'd7, 32'd9);     idle(34);

    // cancel mid-divide, then a fresh MULT
    req(3'd3, 32'd12345, 32'd17); idle(8);
    @(negedge clk) bus.cancel = 1'b1;
    @(negedge clk) bus.cancel = 1'b0;
    idle(40);
    req(3'd1, 32'hFFFF_FFF0, 32'd5); idle(3);

    // reset mid-divide, then a fresh MULT
    req(3'd3, 32'd999, 32'd4); idle(3);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    idle(2);
    req(3'd1, 32'd6, 32'hFFFF_FFFF); idle(3);

    // cancel with start in the same cycle
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd5; bus.opa = 32'hDEAD_BEEF; bus.cancel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    idle(2);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 511) != 0);
      bus.cancel = ($urandom_range(0, 63) == 0);
      bus.start  = ($urandom_range(0, 3) == 0);
      bus.op     = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: begin bus.opa = 32'h8000_0000; bus.opb = 32'hFFFF_FFFF; end
        1: begin bus.opa = $urandom; bus.opb = '0; end
        2: begin bus.opa = $urandom; bus.opb = 32'($urandom_range(1, 15)); end
        3: begin bus.opa = 32'($urandom_range(0, 300)); bus.opb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)); end
        default: begin bus.opa = $urandom; bus.opb = $urandom; end
      endcase
    end
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0; rst = 1'b1;
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu_hilo_writer.md
Name: mdu_hilo_writer

Overview:
- Multiply/divide unit for the MIPS pipeline.
- Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO requests from the EX stage.
- Computes results (iteratively for divides) and drives the HI/LO register write port: write enables plus data.
- Asserts a busy/stall signal to the pipeline while an operation is in flight.

Parameters:
- DATA_W, 32, operand and HI/LO width; divide takes DATA_W iterations.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-low (rst==0 resets on posedge clk).
- start  input  1  request valid for one cycle.
- op  input  3  0=NOP, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO, 7=NOP.
- opa  input  DATA_W  rs operand (dividend / multiplicand / MTHI-MTLO data).
- opb  input  DATA_W  rt operand (divisor / multiplier).
- cancel  input  1  pipeline flush; aborts any in-flight operation.
- busy  output  1  high while an accepted op has not yet written; pipeline stalls on it.
- we_hi  output  1  one-cycle HI write strobe.
- hi_data_out  output  DATA_W  HI write data.
- we_lo  output  1  one-cycle LO write strobe.
- lo_data_out  output  DATA_W  LO write data.

Behaviour:
Reset:
- On posedge clk with rst==0, all outputs go to 0: busy, we_hi, we_lo, hi_data_out, lo_data_out.
- FSM goes to IDLE and the iteration counter clears.
- Reset mid-operation discards the operation; no write occurs.

FSM states: IDLE, MUL, DIV, DONE.

Accept rule:
- In IDLE, with start=1, cancel=0 and op in 1..6, operands are latched at posedge T.
- start while busy=1, or any op 0/7, is ignored.

MTHI / MTLO:
- IDLE -> DONE. At T+1, only the matching strobe goes high for one cycle, with data=opa.
- The other strobe stays 0. busy is never raised.

MULT / MULTU:
- IDLE -> MUL (T+1, busy=1), full 2*DATA_W product registered -> DONE.
- At T+2: we_hi=we_lo=1 for one cycle; hi=product[2W-1:W], lo=product[W-1:0].
- MULT is two's-complement signed; MULTU is unsigned.

DIV / DIVU:
- IDLE -> DIV. Restoring radix-2 divide on magnitudes, one quotient bit per cycle.
- busy=1 from T+1 through T+DATA_W+1. Both strobes fire at T+DATA_W+2 (T+34 for W=32); lo=quotient, hi=remainder.
- Signed: quotient is negated if operand signs differ; remainder takes the sign of the dividend.
- Overflow case: -2^(W-1) / -1 gives lo=0x80000000, hi=0.
- Divide by zero (opb==0): no iteration. DIV -> DONE directly; strobes at T+2 with lo=all-ones and hi=opa. Applies to both DIV and DIVU.

DONE:
- Strobes and data are valid this cycle only; busy=0.
- FSM returns to IDLE next cycle.
- Outside DONE, we_hi=we_lo=0. Data outputs hold their last value.
- A new start is accepted in the cycle after DONE (back-to-back with one idle gap).

Cancel:
- cancel=1 in any state forces IDLE at the next posedge. busy then drops and no strobe fires.
- cancel in the DONE cycle does not retract strobes already driven.
- cancel with start in the same cycle: the start is not accepted.
- rst takes priority over cancel, and cancel over start.

Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- MULT signed: opa=0xFFFFFFFE (-2), opb=0x00000003 -> at T+2, we_hi=we_lo=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high at T+1 only.
- MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV: opa=0xFFFFFFF9 (-7), opb=2 -> busy T+1..T+33; strobes at T+34 with lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- Divide edge cases:
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU 5/0 -> at T+2, lo=0xFFFFFFFF, hi=5.
- MTHI opa=0x12345678 -> at T+1, we_hi=1, hi=0x12345678, we_lo=0, busy stays 0. A start issued during a DIV's busy window is ignored (no extra strobe).
- Abort cases:
  - cancel asserted at T+10 of a DIV -> busy=0 at T+11; no strobe ever fires.
  - rst=0 at T+5 of a DIV -> all outputs 0 next cycle.
  - A fresh MULT after either abort completes normally.
